// File: rtl/booth_product_collector.sv
// booth_product_collector: captures each Booth product into a FWFT FIFO with valid/ready output and optional MAC accumulator
module booth_product_collector #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 40
) (
  input  logic                     clk_in,
  input  logic                     mrst,
  input  logic [31:0]              product,
  input  logic                     prod_done,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overrun,
  input  logic                     ovr_clr,
  input  logic                     acc_en,
  input  logic                     acc_clr,
  output logic [ACC_W-1:0]         acc_out,
  output logic                     acc_ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic done_q, cap, pop, push, drop, add_ovf, acc_cap;
  logic [ACC_W-1:0] ext, sum;
  assign out_valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign out_data = out_valid ? mem[rd_ptr] : '0;
  always_comb begin
    cap = prod_done & ~done_q;
    pop = out_valid & out_ready;
    push = cap & (~full | pop);
    drop = cap & full & ~pop;
    acc_cap = cap & acc_en;
    ext = {{(ACC_W-32){product[31]}}, product};
    sum = acc_out + ext;
    add_ovf = (acc_out[ACC_W-1] == ext[ACC_W-1]) & (sum[ACC_W-1] != acc_out[ACC_W-1]);
  end
  // done_q resets high so a done level already present at release is not a new product
  always_ff @(posedge clk_in or posedge mrst)
    if (mrst) begin
      done_q  <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      acc_out <= '0;
      acc_ovf <= 1'b0;
    end else begin
      done_q  <= prod_done;
      wr_ptr  <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count   <= count + {AW'(0), push} - {AW'(0), pop};
      overrun <= drop | (overrun & ~ovr_clr);
      acc_out <= acc_clr ? (acc_cap ? ext : '0) : (acc_cap ? sum : acc_out);
      acc_ovf <= ~acc_clr & (acc_ovf | (acc_cap & add_ovf));
    end
  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr] <= product;
endmodule
